traffic_light_phase_controller: RTL and testbench
=================================================

Name: traffic_light_phase_controller

Overview:
Parametrised, demand-actuated successor to the fixed-sequence crossing controller. It drives NUM_DIR approaches through GREEN -> YELLOW -> ALL_RED phases in round-robin order, and skips approaches with no latched vehicle demand. Green time is extended up to a maximum while the served approach still detects vehicles. A night/fault flash mode is also provided. Clocked by the 1 Hz system tick (one clk cycle = 1 s); drives lamp drivers directly.

Parameters:
NUM_DIR, 4, number of approaches (2..8)
CNT_W, 6, phase counter width; all times must be <= 2^CNT_W
GREEN_MIN, 10, minimum green cycles
GREEN_MAX, 30, maximum green cycles while other demand pending
YELLOW_TIME, 3, yellow cycles
ALLRED_TIME, 2, all-red clearance cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
vehicle_detect  input  NUM_DIR  per-approach detector, synchronous to clk
flash_mode  input  1  request flash operation, synchronous, level
lights  output  3*NUM_DIR  per approach i: [3i+2]=R, [3i+1]=Y, [3i]=G
state  output  3  0=GREEN, 1=YELLOW, 2=ALL_RED, 3=FLASH (others unused)
counter  output  CNT_W  cycles elapsed in current state
active_dir  output  clog2(NUM_DIR)  approach currently served

Behaviour:
- Single clock; reset is asynchronous and active-low. rst=0 immediately forces: state=GREEN, active_dir=0, counter=0, demand_q=0, lights = approach 0 G and all others R. The default reset value of lights is 0x921.
- All outputs are registered. Lights are decoded from registered state/active_dir/counter with no combinational path from the inputs.
- demand_q[i] is set when vehicle_detect[i]=1. It is not set for active_dir while state=GREEN. It is cleared for the approach that enters GREEN on that edge; clear wins over set.
- other_dem = |(demand_q & ~onehot(active_dir)). It uses registered demand only (one-cycle latency from detect).
- Counter increments every cycle. It resets to 0 on each state change and saturates at GREEN_MAX-1 in GREEN. In FLASH it wraps freely.
- GREEN -> YELLOW when either of the following holds:
  - flash_mode=1, regardless of GREEN_MIN; or
  - other_dem=1 and counter>=GREEN_MIN-1 and (vehicle_detect[active_dir]=0 or counter==GREEN_MAX-1).
  - If other_dem=0, the approach rests in green indefinitely.
- YELLOW -> ALL_RED at counter==YELLOW_TIME-1.
- ALL_RED exit at counter==ALLRED_TIME-1:
  - if flash_mode=1 -> FLASH;
  - else -> GREEN for the next approach, cyclically from active_dir+1, with demand_q set (dir itself excluded). If none is set, GREEN on approach 0. active_dir updates on the same edge.
- FLASH lights:
  - counter[0]=0: approach 0 Y, all others R.
  - counter[0]=1: all lamps off.
- FLASH -> ALL_RED (full ALLRED_TIME) when flash_mode=0, then resumes via the normal ALL_RED exit rule.
- Lights in other states:
  - GREEN: active G, others R.
  - YELLOW: active Y, others R.
  - ALL_RED: all R.
- Exactly one lamp per approach is lit outside FLASH. No two approaches are ever non-red simultaneously.
- Simultaneous events:
  - flash_mode rising in YELLOW/ALL_RED does not shorten them.
  - Detect on the entering approach at the ALL_RED->GREEN edge is discarded.

Test Plan:
1. Reset held 5 cycles, no detects -> lights=0x921, state=0, active_dir=0; counter reaches 29 and holds; no phase change after 100 cycles.
2. vehicle_detect=4'b0100 for 1 cycle at cycle 5 after reset release -> 10 cycles green, then lights=0x922 for 3 cycles, 0x924 for 2 cycles, then 0x864 (approach 2 green, approach 1 skipped), active_dir=2.
3. vehicle_detect=4'b0011 held -> approach 0 green for exactly 30 cycles (GREEN_MAX), then yellow/all-red, then approach 1 green.
4. vehicle_detect=4'b1111 held -> green order 0,1,2,3,0; each green lasts 30 cycles; 5 cycles of clearance between greens.
5. flash_mode=1 at counter=4 in GREEN -> YELLOW on the next edge, 3 yellow, 2 all-red, then state=3 with lights alternating 0x922/0x000 each cycle. flash_mode=0 -> 2 cycles 0x924, then 0x921.
6. rst driven low mid-YELLOW, between clock edges -> lights=0x921 and state=0 immediately without a clock edge; demand_q cleared; the previous approach is not resumed.

Source files
------------

// File: rtl/traffic_light_phase_controller.sv
// Demand-actuated multi-approach traffic light controller with green extension,
// skip-on-no-demand round robin and a night/fault flash mode. One clk = 1 s.
module traffic_light_phase_controller #(
    parameter int unsigned  NUM_DIR     = 4,
    parameter int unsigned  CNT_W       = 6,
    parameter int unsigned  GREEN_MIN   = 10,
    parameter int unsigned  GREEN_MAX   = 30,
    parameter int unsigned  YELLOW_TIME = 3,
    parameter int unsigned  ALLRED_TIME = 2,
    localparam int unsigned DIR_W       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DIR-1:0]   vehicle_detect,
    input  logic                 flash_mode,
    output logic [3*NUM_DIR-1:0] lights,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     counter,
    output logic [DIR_W-1:0]     active_dir
);

    localparam int unsigned      LW       = 3 * NUM_DIR;
    localparam logic [CNT_W-1:0] G_MIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_M1     = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_M1    = CNT_W'(ALLRED_TIME - 1);

    typedef enum logic [2:0] {
        PH_GREEN  = 3'd0,
        PH_YELLOW = 3'd1,
        PH_ALLRED = 3'd2,
        PH_FLASH  = 3'd3
    } phase_e;

    phase_e             cur_ph, nxt_ph;
    logic [DIR_W-1:0]   dir_q, nxt_dir, sel_dir;
    logic [CNT_W-1:0]   cnt_q, nxt_cnt;
    logic [NUM_DIR-1:0] demand_q, demand_d, dir_mask;
    logic [LW-1:0]      lights_q, lights_d;
    logic               other_dem, sel_found;

    // Lamp pattern per phase; approach 0 ends up in the lowest triplet.
    function automatic logic [LW-1:0] decode(input phase_e ph, input logic [DIR_W-1:0] dir,
                                             input logic blink);
        logic [LW-1:0] l;
        logic [2:0]    lamp;
        l = '0;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            lamp = 3'b100;
            unique case (ph)
                PH_GREEN:  if (DIR_W'(i) == dir) lamp = 3'b001;
                PH_YELLOW: if (DIR_W'(i) == dir) lamp = 3'b010;
                PH_FLASH:  lamp = blink ? 3'b000 : ((i == 0) ? 3'b010 : 3'b100);
                default:   lamp = 3'b100;
            endcase
            l = {lamp, l[LW-1:3]};
        end
        return l;
    endfunction

    // Next approach with pending demand, scanning cyclically after the current one.
    always_comb begin
        sel_dir   = '0;
        sel_found = 1'b0;
        for (int unsigned k = 1; k < NUM_DIR; k++) begin
            if (!sel_found && demand_q[DIR_W'((32'(dir_q) + k) % NUM_DIR)]) begin
                sel_found = 1'b1;
                sel_dir   = DIR_W'((32'(dir_q) + k) % NUM_DIR);
            end
        end
    end

    always_comb begin
        nxt_ph    = cur_ph;
        nxt_dir   = dir_q;
        dir_mask  = NUM_DIR'(1) << dir_q;
        other_dem = |(demand_q & ~dir_mask);
        demand_d  = demand_q | (vehicle_detect & ~((cur_ph == PH_GREEN) ? dir_mask : '0));

        unique case (cur_ph)
            PH_GREEN: begin
                if (flash_mode || (other_dem && (cnt_q >= G_MIN_M1) &&
                    (!vehicle_detect[dir_q] || (cnt_q == G_MAX_M1))))
                    nxt_ph = PH_YELLOW;
            end
            PH_YELLOW: begin
                if (cnt_q == Y_M1) nxt_ph = PH_ALLRED;
            end
            PH_ALLRED: begin
                if (cnt_q == AR_M1) begin
                    if (flash_mode) begin
                        nxt_ph = PH_FLASH;
                    end else begin
                        nxt_ph   = PH_GREEN;
                        nxt_dir  = sel_dir;
                        // entering approach is served now; a detect on this edge is dropped
                        demand_d = demand_d & ~(NUM_DIR'(1) << sel_dir);
                    end
                end
            end
            PH_FLASH: begin
                if (!flash_mode) nxt_ph = PH_ALLRED;
            end
            default: nxt_ph = PH_GREEN;
        endcase

        if (nxt_ph != cur_ph)
            nxt_cnt = '0;
        else if ((cur_ph == PH_GREEN) && (cnt_q >= G_MAX_M1))
            nxt_cnt = G_MAX_M1;
        else
            nxt_cnt = cnt_q + CNT_W'(1);

        lights_d = decode(nxt_ph, nxt_dir, nxt_cnt[0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_ph   <= PH_GREEN;
            dir_q    <= '0;
            cnt_q    <= '0;
            demand_q <= '0;
            lights_q <= decode(PH_GREEN, '0, 1'b0);
        end else begin
            cur_ph   <= nxt_ph;
            dir_q    <= nxt_dir;
            cnt_q    <= nxt_cnt;
            demand_q <= demand_d;
            lights_q <= lights_d;
        end
    end

    assign lights     = lights_q;
    assign state      = 3'(cur_ph);
    assign counter    = cnt_q;
    assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_light_phase_controller.sv
// Bench for traffic_light_phase_controller: directed segment table, async reset
// mid-yellow, then randomized traffic checked against a behavioural model.
module tb_traffic_light_phase_controller;

    localparam int N    = 4;
    localparam int CW   = 6;
    localparam int GMIN = 10;
    localparam int GMAX = 30;
    localparam int YT   = 3;
    localparam int ART  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  vehicle_detect;
    logic          flash_mode;
    logic [3*N-1:0] lights;
    logic [2:0]    state;
    logic [CW-1:0] counter;
    logic [1:0]    active_dir;

    traffic_light_phase_controller #(
        .NUM_DIR(N), .CNT_W(CW), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_TIME(YT), .ALLRED_TIME(ART)
    ) dut (
        .clk(clk), .rst(rst), .vehicle_detect(vehicle_detect), .flash_mode(flash_mode),
        .lights(lights), .state(state), .counter(counter), .active_dir(active_dir)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Model: phase 0=green 1=yellow 2=all-red 3=flash
    int m_ph, m_dir, m_cnt;
    bit m_dem [N];

    typedef struct {
        int         n;
        logic [3:0] vd;
        logic       fl;
        int         st;
        int         dir;
        int         cnt;
        int         lt;
    } seg_t;

    seg_t segs [19];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int model_lights(input int ph, input int dir, input int cnt);
        int v;
        int lamp;
        v = 0;
        for (int i = 0; i < N; i++) begin
            if (ph == 3)                  lamp = (cnt % 2 == 1) ? 0 : ((i == 0) ? 2 : 4);
            else if (ph == 2 || i != dir) lamp = 4;
            else                          lamp = (ph == 0) ? 1 : 2;
            v += lamp << (3 * i);
        end
        return v;
    endfunction

    function automatic void model_reset();
        m_ph  = 0;
        m_dir = 0;
        m_cnt = 0;
        for (int i = 0; i < N; i++) m_dem[i] = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] v, input logic f);
        int vi;
        int ph_n, dir_n, cnt_n, j;
        bit other, found;
        bit dem_n [N];
        vi    = int'(v);
        ph_n  = m_ph;
        dir_n = m_dir;
        other = 1'b0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            dem_n[i] = m_dem[i];
            if (i != m_dir && m_dem[i]) other = 1'b1;
            if (((vi >> i) & 1) == 1 && !(m_ph == 0 && i == m_dir)) dem_n[i] = 1'b1;
        end
        case (m_ph)
            0: if (f || (other && m_cnt >= GMIN - 1 &&
                         (((vi >> m_dir) & 1) == 0 || m_cnt == GMAX - 1))) ph_n = 1;
            1: if (m_cnt == YT - 1) ph_n = 2;
            2: if (m_cnt == ART - 1) begin
                   if (f) ph_n = 3;
                   else begin
                       ph_n  = 0;
                       dir_n = 0;
                       for (int k = 1; k < N; k++) begin
                           j = (m_dir + k) % N;
                           if (!found && m_dem[j]) begin
                               found = 1'b1;
                               dir_n = j;
                           end
                       end
                       dem_n[dir_n] = 1'b0;
                   end
               end
            default: if (!f) ph_n = 2;
        endcase
        if (ph_n != m_ph)  cnt_n = 0;
        else if (m_ph == 0) cnt_n = (m_cnt + 1 > GMAX - 1) ? GMAX - 1 : m_cnt + 1;
        else               cnt_n = (m_cnt + 1) % (1 << CW);
        m_ph  = ph_n;
        m_dir = dir_n;
        m_cnt = cnt_n;
        for (int i = 0; i < N; i++) m_dem[i] = dem_n[i];
    endfunction

    task automatic tick(input logic [N-1:0] v, input logic f);
        vehicle_detect = v;
        flash_mode     = f;
        @(posedge clk);
        model_step(v, f);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".state"},   int'(state),      m_ph);
        check({tag, ".dir"},     int'(active_dir), m_dir);
        check({tag, ".counter"}, int'(counter),    m_cnt);
        check({tag, ".lights"},  int'(lights),     model_lights(m_ph, m_dir, m_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] hold_pat;
        logic         fl;
        int           mode;
        int           w;

        segs[0]  = '{40, 4'b0000, 1'b0, 0, 0, 29, 'h921};
        segs[1]  = '{ 1, 4'b0100, 1'b0, 0, 0, 29, 'h921};
        segs[2]  = '{ 1, 4'b0000, 1'b0, 1, 0,  0, 'h922};
        segs[3]  = '{ 2, 4'b0000, 1'b0, 1, 0,  2, 'h922};
        segs[4]  = '{ 1, 4'b0000, 1'b0, 2, 0,  0, 'h924};
        segs[5]  = '{ 1, 4'b0000, 1'b0, 2, 0,  1, 'h924};
        segs[6]  = '{ 1, 4'b0000, 1'b0, 0, 2,  0, 'h864};
        segs[7]  = '{ 1, 4'b0001, 1'b0, 0, 2,  1, 'h864};
        segs[8]  = '{ 8, 4'b0100, 1'b0, 0, 2,  9, 'h864};
        segs[9]  = '{20, 4'b0100, 1'b0, 0, 2, 29, 'h864};
        segs[10] = '{ 1, 4'b0100, 1'b0, 1, 2,  0, 'h8A4};
        segs[11] = '{ 1, 4'b0000, 1'b1, 1, 2,  1, 'h8A4};
        segs[12] = '{ 2, 4'b0000, 1'b1, 2, 2,  0, 'h924};
        segs[13] = '{ 2, 4'b0000, 1'b1, 3, 2,  0, 'h922};
        segs[14] = '{ 1, 4'b0000, 1'b1, 3, 2,  1, 'h000};
        segs[15] = '{ 1, 4'b0000, 1'b1, 3, 2,  2, 'h922};
        segs[16] = '{ 1, 4'b0000, 1'b0, 2, 2,  0, 'h924};
        segs[17] = '{ 2, 4'b0000, 1'b0, 0, 0,  0, 'h921};
        segs[18] = '{40, 4'b0000, 1'b0, 0, 0, 29, 'h921};

        rst            = 1'b1;
        vehicle_detect = '0;
        flash_mode     = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        check("reset.lights",  int'(lights),     'h921);
        check("reset.state",   int'(state),      0);
        check("reset.dir",     int'(active_dir), 0);
        check("reset.counter", int'(counter),    0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;

        // Directed segments: skip, extension to max, flash entry/exit, demand resume
        for (int s = 0; s < 19; s++) begin
            for (int c = 0; c < segs[s].n; c++) tick(segs[s].vd, segs[s].fl);
            check($sformatf("seg%0d.state", s),   int'(state),      segs[s].st);
            check($sformatf("seg%0d.dir", s),     int'(active_dir), segs[s].dir);
            check($sformatf("seg%0d.counter", s), int'(counter),    segs[s].cnt);
            check($sformatf("seg%0d.lights", s),  int'(lights),     segs[s].lt);
        end

        // Async reset between edges in the middle of a yellow
        tick(4'b0010, 1'b0);
        w = 0;
        while (state != 3'd1 && w < 10) begin
            tick(4'b0000, 1'b0);
            w++;
        end
        check("midyel.reach", int'(state), 1);
        tick(4'b0000, 1'b0);
        #3 rst = 1'b0;
        #1;
        check("midyel.lights",  int'(lights),     'h921);
        check("midyel.state",   int'(state),      0);
        check("midyel.dir",     int'(active_dir), 0);
        check("midyel.counter", int'(counter),    0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        for (int c = 0; c < 40; c++) begin
            tick(4'b0000, 1'b0);
            compare_model($sformatf("postrst%0d", c));
        end
        check("postrst.rest_dir", int'(active_dir), 0);
        check("postrst.rest_cnt", int'(counter),    29);

        // Randomized traffic with occasional flash requests
        fl       = 1'b0;
        mode     = 0;
        hold_pat = '0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 60 == 0) begin
                mode     = int'($urandom_range(0, 3));
                hold_pat = 4'($urandom);
            end
            if ($urandom_range(0, 119) == 0) fl = ~fl;
            case (mode)
                0:       v = '0;
                1:       v = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
                2:       v = hold_pat;
                default: v = 4'($urandom);
            endcase
            tick(v, fl);
            compare_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
